wbc_dec_round_ctrl: RTL and testbench

Iterative round controller that feeds the 128-bit white-box decryption WARX layer (eight parallel 16-bit mSPECKEY decryption boxes) and consumes its output.
- Holds the cipher state in a register and drives it to the WARX layer each cycle.
- Takes the layer's combinational result back in, applies the inverse word-rotation/round-constant linear layer, and iterates for ROUNDS rounds.
- Sits between the block's valid/ready input stream and the plaintext output stream.

---
 rtl/wbc_dec_round_ctrl.sv | 98 +++++++++
 tb/tb_wbc_dec_round_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wbc_dec_round_ctrl.sv
// Iterative round controller for the 128-bit white-box WARX decryption layer.
// Optional synchronous abort input is enabled by defining WBC_DEC_ABORT_EN.
module wbc_dec_round_ctrl #(
    parameter int unsigned ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef WBC_DEC_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [127:0] warx_state_o,
    input  logic [127:0] warx_state_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    localparam int unsigned CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    fsm_t             fsm;
    logic [127:0]     state_q;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     lin;
    logic             kill;

`ifdef WBC_DEC_ABORT_EN
    assign kill = abort && (fsm != IDLE);
`else
    assign kill = 1'b0;
`endif

    // Inverse linear layer: rotate left one word, fold the round counter into word 0.
    always_comb begin
        lin        = {warx_state_i[111:0], warx_state_i[127:112]};
        lin[15:0]  = lin[15:0] ^ 16'(cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_q   <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (kill) begin
            fsm       <= IDLE;
            state_q   <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q  <= in_data;
                        cnt      <= CNT_W'(ROUNDS - 1);
                        fsm      <= ROUND;
                        in_ready <= 1'b0;
                    end
                end
                ROUND: begin
                    if (cnt != '0) begin
                        state_q <= lin;
                        cnt     <= cnt - 1'b1;
                    end else begin
                        state_q   <= warx_state_i;
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign warx_state_o = state_q;
    assign out_data     = state_q;

endmodule

// File: tb/tb_wbc_dec_round_ctrl.sv
// Scoreboarded bench: ROUNDS=10 unit with a behavioural WARX box model, ROUNDS=2 unit in loopback.
`timescale 1ns/1ps
module tb_wbc_dec_round_ctrl;
    localparam int unsigned R_A = 10;
    localparam int unsigned R_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [127:0] a_in_data = '0, a_wo, a_wi, a_out_data;
    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [127:0] b_in_data = '0, b_wo, b_wi, b_out_data;
`ifdef WBC_DEC_ABORT_EN
    logic a_abort = 1'b0;
    logic b_abort = 1'b0;
`endif

    wbc_dec_round_ctrl #(.ROUNDS(R_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
`ifdef WBC_DEC_ABORT_EN
        .abort(a_abort),
`endif
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .warx_state_o(a_wo), .warx_state_i(a_wi),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    wbc_dec_round_ctrl #(.ROUNDS(R_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
`ifdef WBC_DEC_ABORT_EN
        .abort(b_abort),
`endif
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .warx_state_o(b_wo), .warx_state_i(b_wi),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    // 16-bit decryption box: inverse Speck-style round on two bytes with a per-box key.
    function automatic logic [15:0] msk_dec(input logic [15:0] w, input int k);
        logic [7:0] l, r, kk;
        l  = w[15:8];
        r  = w[7:0];
        kk = 8'h5A ^ 8'(k * 37);
        r  = r ^ l;
        r  = {r[1:0], r[7:2]};
        l  = (l ^ kk) - r;
        l  = {l[4:0], l[7:5]};
        return {l, r};
    endfunction

    function automatic logic [127:0] warx_layer(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 8; k++) o[16*k +: 16] = msk_dec(s[16*k +: 16], k);
        return o;
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] din, input int unsigned rounds);
        logic [15:0]  s[8];
        logic [15:0]  t[8];
        logic [127:0] o;
        for (int k = 0; k < 8; k++) s[k] = din[16*k +: 16];
        for (int unsigned r = 0; r < rounds; r++) begin
            int unsigned c;
            c = rounds - 1 - r;
            for (int k = 0; k < 8; k++) t[k] = msk_dec(s[k], k);
            if (c == 0) s = t;
            else begin
                for (int j = 0; j < 8; j++) s[j] = t[(j + 7) % 8];
                s[0] = s[0] ^ 16'(c);
            end
        end
        for (int k = 0; k < 8; k++) o[16*k +: 16] = s[k];
        return o;
    endfunction

    always_comb a_wi = warx_layer(a_wo);
    assign b_wi = b_wo;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;
    exp_t q[$];

    bit stall_en = 1'b0;
    always @(posedge clk) begin
        #1 a_out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Output-side monitor for unit A.
    logic         prev_ov = 1'b0, prev_rdy = 1'b0;
    logic [127:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            check(a_in_ready == (q.size() == 0), "in_ready_busy", 128'(a_in_ready), 128'(q.size() == 0));
            if (a_out_valid && !prev_ov) begin
                if (q.size() == 0) check(1'b0, "unexpected_out", a_out_data, '0);
                else check((cyc - q[0].acc) == R_A, "latency", 128'(cyc - q[0].acc), 128'(R_A));
            end
            if (a_out_valid && prev_ov && !prev_rdy)
                check(a_out_data == prev_data, "stable", a_out_data, prev_data);
            if (a_out_valid && a_out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check(a_out_data == e.data, "data", a_out_data, e.data);
            end
            prev_ov   = a_out_valid;
            prev_rdy  = a_out_ready;
            prev_data = a_out_data;
        end
    end

    int last_acc = -1;
    task automatic send_a(input logic [127:0] d, input bit keep, input bit b2b);
        int n;
        n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!a_in_ready && n < 200);
        check(a_in_ready, "accept_timeout", 128'(a_in_ready), 128'(1));
        @(posedge clk);
        #1;
        q.push_back('{data: ref_dec(d, R_A), acc: cyc});
        if (b2b && last_acc >= 0)
            check((cyc - last_acc) == R_A + 2, "b2b_spacing", 128'(cyc - last_acc), 128'(R_A + 2));
        last_acc = cyc;
        if (!keep) a_in_valid = 1'b0;
    endtask

    task automatic run_b(input logic [127:0] d, input logic [127:0] exp);
        int n, acc;
        n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!b_in_ready && n < 50);
        @(posedge clk);
        #1;
        acc = cyc;
        b_in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_out_valid && n < 50);
        check(b_out_valid && (cyc - acc) == R_B, "b_latency", 128'(cyc - acc), 128'(R_B));
        check(b_out_data == exp, "b_data", b_out_data, exp);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1 b_out_ready = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] w7;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check(a_in_ready == 1'b1 && a_out_valid == 1'b0, "reset_hs", {a_in_ready, a_out_valid}, 2'b10);
        check(a_out_data == '0 && a_wo == '0, "reset_data", a_out_data | a_wo, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_b('0, 128'h1);
        w7 = '0;
        w7[127:112] = 16'hABCD;
        run_b(w7, 128'h0000_0000_0000_0000_0000_0000_0000_ABCC);

        stall_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_a(rnd128(), 1'b0, 1'b0);
        end

        stall_en = 1'b0;
        last_acc = -1;
        for (int i = 0; i < 20; i++) send_a(rnd128(), 1'b1, 1'b1);
        a_in_valid = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check(q.size() == 0, "drain", 128'(q.size()), '0);

        // Reset while a block is mid-flight.
        send_a(rnd128(), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        check(a_out_valid == 1'b0 && a_in_ready == 1'b1, "rst_mid_hs", {a_in_ready, a_out_valid}, 2'b10);
        check(a_wo == '0 && a_out_data == '0, "rst_mid_state", a_wo | a_out_data, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;

`ifdef WBC_DEC_ABORT_EN
        send_a(rnd128(), 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 a_abort = 1'b1;
        @(posedge clk);
        #1 a_abort = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        check(a_in_ready == 1'b1 && a_out_valid == 1'b0, "abort_hs", {a_in_ready, a_out_valid}, 2'b10);
        check(a_wo == '0, "abort_state", a_wo, '0);
        repeat (15) @(posedge clk);
        #1;
        send_a(rnd128(), 1'b0, 1'b0);
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check(q.size() == 0, "abort_next", 128'(q.size()), '0);
`endif

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
